// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct and ALU codes for the multicycle controller
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // aluop[1] selects funct decode, aluop[0] forces subtract
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: maps aluop and funct to the ALU operation code
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    always_comb begin
        alucontrol = !aluop[1] ? (aluop[0] ? ALU_SUB : ALU_ADD) :
                     funct == F_SUB ? ALU_SUB :
                     funct == F_AND ? ALU_AND :
                     funct == F_OR  ? ALU_OR  :
                     funct == F_SLT ? ALU_SLT : ALU_ADD;
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS-subset Moore control FSM with retired-instruction counter
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic                 pcen,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 iord,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [2:0]           alucontrol,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instret
);
    state_t     state, next;
    logic [1:0] aluop;
    logic       pcwrite, branch, retire;

    alu_decoder u_alu_decoder (.aluop(aluop), .funct(funct), .alucontrol(alucontrol));

    // only completed instructions retire; DECODE->FETCH is the illegal-op path
    assign retire = next == FETCH && state != FETCH && state != DECODE;
    assign pcen   = pcwrite | (branch & zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= next;
            if (retire)
                instret <= instret + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        next       = FETCH;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                next    = DECODE;
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = RTYPEEX;
                    OP_BEQ:       next = BEQEX;
                    OP_ADDI:      next = ADDIEX;
                    OP_J:         next = JEX;
                    default:      illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                next    = op == OP_LW ? MEMRD : MEMWR;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                next = MEMWB;
                iord = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                next    = RTYPEWB;
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                next    = ADDIWB;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: next = FETCH;
        endcase
    end
endmodule
